// File: rtl/approx_sweep_pkg.sv
// approx_sweep_pkg: sweep FSM state encoding and default circuit width / error threshold
package approx_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 3;
  localparam int DEF_ET    = 4;
endpackage

// File: rtl/approx_abs_diff.sv
// approx_abs_diff: d = |a - b| for unsigned a, b (computed in N_OUT+1 bits, truncated to N_OUT)
module approx_abs_diff #(
  parameter int N_OUT = 3
) (
  input  logic [N_OUT-1:0] a,
  input  logic [N_OUT-1:0] b,
  output logic [N_OUT-1:0] d
);
  logic [N_OUT:0] diff;
  assign diff = {1'b0, a} - {1'b0, b};
  assign d = diff[N_OUT] ? N_OUT'(-diff) : diff[N_OUT-1:0];
endmodule

// File: rtl/approx_err_sweeper.sv
// approx_err_sweeper: sweeps vec over all inputs, accumulates |approx-exact| stats (max, sum, violations, first failing vec) and reports pass/done
module approx_err_sweeper
  import approx_sweep_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int ET    = DEF_ET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [N_IN-1:0]       vec,
  input  logic [N_OUT-1:0]      approx_out,
  input  logic [N_OUT-1:0]      exact_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN+N_OUT-1:0] err_sum,
  output logic [N_IN:0]         viol_cnt,
  output logic [N_IN-1:0]       fail_vec,
  output logic                  fail_valid
);
  state_t                state_q;
  logic [N_IN-1:0]       vec_q, p1_vec_q, fvec_q, fvec_d;
  logic [N_OUT-1:0]      p1_a_q, p1_e_q, max_q, max_d, d;
  logic [N_IN+N_OUT-1:0] sum_q, sum_d;
  logic [N_IN:0]         viol_q, viol_d;
  logic                  p1_v_q, busy_q, done_q, pass_q, fval_q, fval_d, acc_en, viol;
  approx_abs_diff #(.N_OUT(N_OUT)) u_diff (.a(p1_a_q), .b(p1_e_q), .d(d));
  assign acc_en = p1_v_q & ~abort;
  assign viol   = int'(d) > ET;
  always_comb begin
    max_d  = (acc_en && d > max_q) ? d : max_q;
    sum_d  = acc_en ? sum_q + (N_IN+N_OUT)'(d) : sum_q;
    viol_d = (acc_en && viol) ? viol_q + (N_IN+1)'(1) : viol_q;
    fvec_d = (acc_en && viol && !fval_q) ? p1_vec_q : fvec_q;
    fval_d = fval_q | (acc_en & viol);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      p1_vec_q <= '0;
      p1_a_q   <= '0;
      p1_e_q   <= '0;
      p1_v_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      max_q    <= '0;
      sum_q    <= '0;
      viol_q   <= '0;
      fvec_q   <= '0;
      fval_q   <= 1'b0;
    end else begin
      p1_vec_q <= vec_q;
      p1_a_q   <= approx_out;
      p1_e_q   <= exact_out;
      p1_v_q   <= (state_q == SWEEP) && !abort;
      done_q   <= 1'b0;
      max_q    <= max_d;
      sum_q    <= sum_d;
      viol_q   <= viol_d;
      fvec_q   <= fvec_d;
      fval_q   <= fval_d;
      if (state_q == IDLE) begin
        if (start && !abort) begin
          state_q <= SWEEP;
          vec_q   <= '0;
          busy_q  <= 1'b1;
          pass_q  <= 1'b0;
          max_q   <= '0;
          sum_q   <= '0;
          viol_q  <= '0;
          fvec_q  <= '0;
          fval_q  <= 1'b0;
        end
      end else if (abort) begin
        state_q <= IDLE;
        vec_q   <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
        fval_q  <= 1'b0;
      end else begin
        case (state_q)
          SWEEP: begin
            vec_q <= vec_q + N_IN'(1);
            if (vec_q == '1) state_q <= DRAIN;
          end
          DRAIN: begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= int'(max_d) <= ET;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign max_err    = max_q;
  assign err_sum    = sum_q;
  assign viol_cnt   = viol_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fval_q;
endmodule

// File: tb/tb_approx_err_sweeper.sv
// tb_approx_err_sweeper: table-driven and random checks of approx_err_sweeper against a whole-sweep reference model
module tb_approx_err_sweeper;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] vec, vec6, fail_vec, fail_vec6;
  logic [2:0] ax, ex, ax6, ex6, max_err, max_err6;
  logic [6:0] err_sum, err_sum6;
  logic [4:0] viol_cnt, viol_cnt6;
  logic busy, done, pass, fail_valid, busy6, done6, pass6, fail_valid6;
  logic [2:0] ap_tab [16];
  logic [2:0] ex_tab [16];
  int tests = 0, failed = 0;

  typedef struct {
    int mode;
    int mx, sum, viol, fvec, fval, pass;
  } vec_t;

  assign ax  = ap_tab[vec];
  assign ex  = ex_tab[vec];
  assign ax6 = ap_tab[vec6];
  assign ex6 = ex_tab[vec6];

  approx_err_sweeper #(.N_IN(4), .N_OUT(3), .ET(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec),
    .approx_out(ax), .exact_out(ex), .busy(busy), .done(done), .pass(pass),
    .max_err(max_err), .err_sum(err_sum), .viol_cnt(viol_cnt),
    .fail_vec(fail_vec), .fail_valid(fail_valid));

  approx_err_sweeper #(.N_IN(4), .N_OUT(3), .ET(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec6),
    .approx_out(ax6), .exact_out(ex6), .busy(busy6), .done(done6), .pass(pass6),
    .max_err(max_err6), .err_sum(err_sum6), .viol_cnt(viol_cnt6),
    .fail_vec(fail_vec6), .fail_valid(fail_valid6));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: approx = exact, 1: approx = 0, 2: random approx and exact netlists
  task automatic load(input int mode);
    for (int v = 0; v < 16; v++) begin
      ex_tab[v] = (mode == 2) ? 3'($urandom_range(0, 7)) : 3'((v & 3) + (v >> 2));
      ap_tab[v] = (mode == 2) ? 3'($urandom_range(0, 7)) : (mode == 1) ? 3'd0 : ex_tab[v];
    end
  endtask

  function automatic vec_t model(input int et);
    vec_t r;
    r = '{mode: 0, mx: 0, sum: 0, viol: 0, fvec: 0, fval: 0, pass: 0};
    for (int v = 0; v < 16; v++) begin
      int dd;
      dd = int'(ap_tab[v]) - int'(ex_tab[v]);
      if (dd < 0) dd = -dd;
      dd = dd % 8;
      if (dd > r.mx) r.mx = dd;
      r.sum += dd;
      if (dd > et) begin
        r.viol++;
        if (r.fval == 0) begin
          r.fvec = v;
          r.fval = 1;
        end
      end
    end
    r.pass = (r.mx <= et) ? 1 : 0;
    return r;
  endfunction

  task automatic check_res(input vec_t e);
    vec_t e6;
    e6 = model(6);
    chk("max_err", max_err, e.mx);
    chk("err_sum", err_sum, e.sum);
    chk("viol_cnt", viol_cnt, e.viol);
    chk("fail_vec", fail_vec, e.fvec);
    chk("fail_valid", fail_valid, e.fval);
    chk("pass", pass, e.pass);
    chk("et6_max_err", max_err6, e6.mx);
    chk("et6_err_sum", err_sum6, e6.sum);
    chk("et6_viol_cnt", viol_cnt6, e6.viol);
    chk("et6_pass", pass6, e6.pass);
    chk("et6_done", done6, 1);
  endtask

  task automatic run_sweep(input bit mid);
    int cyc;
    bit bad_vec, bad_busy;
    bad_vec = 0;
    bad_busy = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      if (busy !== 1'b1) bad_busy = 1;
      if (cyc <= 16 && int'(vec) != cyc - 1) bad_vec = 1;
      if (mid) start = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, 18);
    chk("busy_window", int'(bad_busy), 0);
    chk("vec_sequence", int'(bad_vec), 0);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_vec"}, vec, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_max_err"}, max_err, 0);
    chk({tag, "_err_sum"}, err_sum, 0);
    chk({tag, "_viol_cnt"}, viol_cnt, 0);
    chk({tag, "_fail_vec"}, fail_vec, 0);
    chk({tag, "_fail_valid"}, fail_valid, 0);
  endtask

  initial begin
    vec_t tab [8];
    vec_t e;
    int cyc;
    bit saw;
    tab[0] = '{mode: 0, mx: 0, sum: 0,  viol: 0, fvec: 0,  fval: 0, pass: 1};
    tab[1] = '{mode: 1, mx: 6, sum: 48, viol: 3, fvec: 11, fval: 1, pass: 0};
    for (int i = 2; i < 8; i++) tab[i] = '{mode: 2, mx: 0, sum: 0, viol: 0, fvec: 0, fval: 0, pass: 0};
    load(0);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      load(tab[i].mode);
      e = (tab[i].mode == 2) ? model(4) : tab[i];
      run_sweep(i == 1);
      check_res(e);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("hold_err_sum", err_sum, e.sum);
      chk("hold_pass", pass, e.pass);
      @(negedge clk);
    end
    // reset in the middle of a sweep
    load(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 7) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_partial_sum", int'(err_sum != 0), 1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    saw = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    chk("midrst_no_done", int'(saw), 0);
    run_sweep(0);
    check_res(tab[1]);
    @(negedge clk);
    // abort at sweep cycle 5 with start held high throughout
    load(1);
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass, 0);
    chk("abort_fail_valid", fail_valid, 0);
    chk("abort_done", done, 0);
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw = 1;
    end
    chk("abort_stays_idle", int'(saw), 0);
    chk("abort_pass_idle", pass, 0);
    // back-to-back sweeps: dirty then clean, start held through DONE is ignored
    load(1);
    run_sweep(0);
    check_res(tab[1]);
    start = 1'b1;
    load(0);
    @(negedge clk);
    chk("b2b_start_in_done_ignored", busy, 0);
    chk("b2b_hold_max_err", max_err, 6);
    chk("b2b_hold_viol_cnt", viol_cnt, 3);
    chk("b2b_hold_fail_vec", fail_vec, 11);
    run_sweep(0);
    check_res(tab[0]);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
